debounce_bank: RTL

- Parametrised N-channel debouncer for board switches and keys.
- Each channel has a 2-flop synchroniser and polarity normalisation. All channels sample on one shared prescaled tick, and each channel has its own stability counter.
- Beyond a debounced level, each channel gives one-cycle press/release pulses and a long-press hold pulse with auto-repeat.
- Sits between raw board I/O and user logic. One instance replaces a bank of per-bit debouncers.

---
 rtl/debounce_channel.sv | 115 +++++++++++
 rtl/debounce_bank.sv | 57 +++++
 2 files changed

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, polarity fix, stability counter,
// edge pulses and long-press hold/auto-repeat. Every output is a flop.
module debounce_channel #(
  parameter bit ACTIVE_LOW   = 1'b0,
  parameter int STABLE_TICKS = 20,
  parameter int HOLD_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int SCNT_W       = 5,
  parameter int HCNT_W       = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_TICKS - 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
  localparam logic [HCNT_W-1:0] REP_LAST  = HCNT_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  logic              sync1_q, sync2_q;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              hold_q, hold_d;
  logic              rep_q, rep_d;
  logic              logical;

  assign logical = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    scnt_d    = scnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hcnt_d    = hcnt_q;
    rep_d     = rep_q;
    hold_d    = 1'b0;

    if (i_tick) begin
      if (logical == level_q) begin
        scnt_d = '0;
      end else if (scnt_q == SCNT_LAST) begin
        scnt_d    = '0;
        level_d   = ~level_q;
        press_d   = logical;
        release_d = ~logical;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end

    // rep_q selects between the first-hold interval and the repeat interval.
    if (!level_q || release_d) begin
      hcnt_d = '0;
      rep_d  = 1'b0;
    end else if (i_tick && HOLD_TICKS != 0) begin
      if (!rep_q) begin
        if (hcnt_q == HOLD_LAST) begin
          hold_d = 1'b1;
          hcnt_d = '0;
          rep_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end else if (REPEAT_TICKS != 0) begin
        if (hcnt_q == REP_LAST) begin
          hold_d = 1'b1;
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (reset) begin
      // NOTE: synchroniser resets to the inactive raw level so the logical value starts at 0.
      sync1_q   <= ACTIVE_LOW;
      sync2_q   <= ACTIVE_LOW;
      scnt_q    <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      sync1_q   <= i_raw;
      sync2_q   <= sync1_q;
      scnt_q    <= scnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_hold    = hold_q;

endmodule

// File: rtl/debounce_bank.sv
// N-channel debouncer: one shared sample-tick prescaler feeding a bank of
// independent debounce_channel instances.
module debounce_bank #(
  parameter int                NUM_CH          = 14,
  parameter int                SAMPLE_DIV      = 50000,
  parameter int                STABLE_TICKS    = 20,
  parameter int                HOLD_TICKS      = 1000,
  parameter int                REPEAT_TICKS    = 200,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = 14'h3C00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] i_raw,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_press,
  output logic [NUM_CH-1:0] o_release,
  output logic [NUM_CH-1:0] o_hold
);

  localparam int PCNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SCNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int HMAX   = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HCNT_W = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SAMPLE_DIV - 1);

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              tick;

  assign tick   = (pcnt_q == PCNT_LAST);
  assign pcnt_d = tick ? '0 : pcnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW_MASK[g]),
      .STABLE_TICKS (STABLE_TICKS),
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .SCNT_W       (SCNT_W),
      .HCNT_W       (HCNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_tick    (tick),
      .i_raw     (i_raw[g]),
      .o_level   (o_level[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g]),
      .o_hold    (o_hold[g])
    );
  end

endmodule
